instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Multi-cycle fetch/decode/execute controller for the 37-bit instruction word.
- Fetches instructions from instruction memory over a req/ack handshake and splits each word into its fields.
- Drives register-file addresses, the immediate and the opcode to the datapath.
- Sequences ALU start/done and register write-back, maintains the program counter and stops on a HALT opcode.

Parameters:
PC_W, 8, program counter / instruction memory address width
RESET_PC, 0, PC value loaded on reset
HALT_OP, 4'hF, opcode value that halts the sequencer

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
start  input  1  begin execution from current pc (sampled in IDLE only)
imem_addr  output  PC_W  instruction address (equals pc)
imem_req  output  1  instruction fetch request
imem_ack  input  1  fetch complete, imem_data valid this cycle
imem_data  input  37  instruction word
opcode  output  4  decoded opcode, IR[20:17]
imm_data  output  16  immediate, IR[36:21]
dst_addr  output  5  destination register, IR[14:10]
src1_addr  output  5  source register 1, IR[9:5]
src2_addr  output  5  source register 2, IR[4:0]
alu_start  output  1  one-cycle ALU start pulse
alu_done  input  1  ALU result valid
rf_we  output  1  one-cycle register-file write strobe
rf_wsel  output  1  write data select: 1 = imm_data, 0 = ALU result
busy  output  1  high in FETCH/DECODE/EXEC/RETIRE
halted  output  1  high in HALT
pc  output  PC_W  program counter
instr_count  output  16  retired instruction count, wraps at 2^16

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high on clk/reset.
- Reset values: state=IDLE, pc=RESET_PC, IR=0 (all field outputs 0), imem_req=0, alu_start=0, rf_we=0, rf_wsel=0, busy=0, halted=0, instr_count=0.
- Reset mid-operation: returns to these values on the same edge. imem_req drops even if no ack was received; no write strobe is issued.
- Instruction field map:
  - [36:21] imm
  - [20:17] opcode
  - [16] load_immediate (LI)
  - [15] read_write (RW)
  - [14:10] dst
  - [9:5] src1
  - [4:0] src2
- Field outputs are registered from IR and change only when IR loads.
- IDLE: start=1 moves to FETCH.
- FETCH:
  - imem_req=1 with imem_addr=pc; held until imem_ack.
  - On the ack cycle, IR<=imem_data and the state moves to DECODE; imem_req is low the following cycle.
  - imem_ack outside FETCH is ignored.
- DECODE (1 cycle), priority order:
  - opcode==HALT_OP → HALT
  - else LI=1 → RETIRE with rf_wsel=1
  - else → EXEC with rf_wsel=0
- EXEC:
  - alu_start=1 only in the first EXEC cycle.
  - alu_done is sampled every EXEC cycle, including the first; alu_done=1 → RETIRE. alu_done outside EXEC is ignored.
- RETIRE (1 cycle):
  - rf_we=1 iff (LI | RW).
  - pc<=pc+1, wrapping modulo 2^PC_W (all-ones → 0).
  - instr_count<=instr_count+1, wrapping.
  - → FETCH.
- HALT:
  - halted=1, busy=0; pc and instr_count frozen; start ignored.
  - Exit only via reset.
  - The HALT instruction is not counted and pc does not advance.
- Latency with zero-wait ack:
  - LI instruction = 3 cycles (FETCH, DECODE, RETIRE).
  - ALU instruction = 4 cycles + extra alu_done wait cycles.

Optional Feature:
SEQ_JUMP_EN
- Defined: opcode 4'hE is an unconditional jump, taking priority over LI in DECODE.
  - DECODE → RETIRE with rf_we=0.
  - RETIRE loads pc<=imm_data[PC_W-1:0] instead of pc+1; instr_count increments.
- Undefined: 4'hE is an ordinary opcode handled by the LI/EXEC rules.

Test Plan:
- Reset, then start=1; word {imm=16'h00AB, op=4'h1, LI=1, RW=0, dst=5'd3} acked same cycle → rf_we=1, rf_wsel=1, dst_addr=3, imm_data=16'h00AB exactly 3 cycles after FETCH entry; pc 0→1, instr_count=1.
- ALU word op=4'h2, LI=0, RW=1, src1=1, src2=2, dst=4; alu_done 2 cycles after alu_start → single alu_start pulse, rf_we=1 with rf_wsel=0 one cycle after alu_done; pc advances by 1.
- ALU word with RW=0 → alu_start pulses, rf_we stays 0 in RETIRE, pc and instr_count still increment.
- imem_ack delayed 5 cycles → imem_req held high with stable imem_addr for 6 cycles; stray alu_done and imem_ack in other states → no effect.
- HALT word (op=4'hF) at pc=2 → halted=1, busy=0, pc stays 2, instr_count unchanged, start ignored; reset → IDLE, pc=RESET_PC.
- PC_W=2, four LI words starting at pc=0 → pc wraps 3→0; assert reset during EXEC → imem_req, alu_start and rf_we all 0 next cycle; with SEQ_JUMP_EN, op=4'hE imm=16'h0002 → pc=2 and rf_we=0.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Instruction-sequencer bus: fetch handshake, decoded fields, ALU/regfile control and status.
// The sequencer connects through the master modport; memory, datapath and controller use slave.
interface instr_sequencer_if #(
    parameter int PC_W = 8
);
    logic            start;
    logic [PC_W-1:0] imem_addr;
    logic            imem_req;
    logic            imem_ack;
    logic [36:0]     imem_data;
    logic [3:0]      opcode;
    logic [15:0]     imm_data;
    logic [4:0]      dst_addr;
    logic [4:0]      src1_addr;
    logic [4:0]      src2_addr;
    logic            alu_start;
    logic            alu_done;
    logic            rf_we;
    logic            rf_wsel;
    logic            busy;
    logic            halted;
    logic [PC_W-1:0] pc;
    logic [15:0]     instr_count;

    modport master (
        input  start, imem_ack, imem_data, alu_done,
        output imem_addr, imem_req, opcode, imm_data, dst_addr, src1_addr, src2_addr,
               alu_start, rf_we, rf_wsel, busy, halted, pc, instr_count
    );

    modport slave (
        output start, imem_ack, imem_data, alu_done,
        input  imem_addr, imem_req, opcode, imm_data, dst_addr, src1_addr, src2_addr,
               alu_start, rf_we, rf_wsel, busy, halted, pc, instr_count
    );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the 37-bit instruction word.
// Optional SEQ_JUMP_EN makes opcode 4'hE an unconditional jump to imm_data.
module instr_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HALT_OP  = 4'hF
) (
    input logic               clk,
    input logic               reset,
    instr_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_RETIRE,
        S_HALT
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [36:0]     r_ir;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_count;
    logic            r_aluFirst;
    logic            r_wsel;
    logic            w_decWsel;
    logic            w_isJump;
    logic            w_li;
    logic            w_rw;
    logic [PC_W-1:0] w_nextPc;

    assign w_li = r_ir[16];
    assign w_rw = r_ir[15];

`ifdef SEQ_JUMP_EN
    assign w_isJump = (r_ir[20:17] == 4'hE);
    assign w_nextPc = w_isJump ? r_ir[21 +: PC_W] : r_pc + PC_W'(1);
`else
    assign w_isJump = 1'b0;
    assign w_nextPc = r_pc + PC_W'(1);
`endif

    always_comb begin
        w_nextState = r_state;
        w_decWsel   = r_wsel;
        case (r_state)
            S_IDLE:   if (bus.start) w_nextState = S_FETCH;
            S_FETCH:  if (bus.imem_ack) w_nextState = S_DECODE;
            S_DECODE: begin
                if (r_ir[20:17] == HALT_OP) begin
                    w_nextState = S_HALT;
                end else if (w_isJump) begin
                    w_nextState = S_RETIRE;
                    w_decWsel   = 1'b0;
                end else if (w_li) begin
                    w_nextState = S_RETIRE;
                    w_decWsel   = 1'b1;
                end else begin
                    w_nextState = S_EXEC;
                    w_decWsel   = 1'b0;
                end
            end
            S_EXEC:   if (bus.alu_done) w_nextState = S_RETIRE;
            S_RETIRE: w_nextState = S_FETCH;
            S_HALT:   w_nextState = S_HALT;
            default:  w_nextState = S_IDLE;
        endcase
    end

    // IR loads only on the ack cycle of FETCH, so stray acks elsewhere leave the fields untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ir       <= '0;
            r_pc       <= RESET_PC;
            r_count    <= '0;
            r_aluFirst <= 1'b0;
            r_wsel     <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_aluFirst <= (r_state == S_DECODE) && (w_nextState == S_EXEC);
            if (r_state == S_FETCH && bus.imem_ack) r_ir <= bus.imem_data;
            if (r_state == S_DECODE) r_wsel <= w_decWsel;
            if (r_state == S_RETIRE) begin
                r_pc    <= w_nextPc;
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.imem_req    = (r_state == S_FETCH);
    assign bus.imm_data    = r_ir[36:21];
    assign bus.opcode      = r_ir[20:17];
    assign bus.dst_addr    = r_ir[14:10];
    assign bus.src1_addr   = r_ir[9:5];
    assign bus.src2_addr   = r_ir[4:0];
    assign bus.alu_start   = (r_state == S_EXEC) && r_aluFirst;
    assign bus.rf_we       = (r_state == S_RETIRE) && (w_li || w_rw) && !w_isJump;
    assign bus.rf_wsel     = r_wsel;
    assign bus.busy        = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                             (r_state == S_EXEC)  || (r_state == S_RETIRE);
    assign bus.halted      = (r_state == S_HALT);
    assign bus.pc          = r_pc;
    assign bus.instr_count = r_count;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: an 8-bit-PC instance driven step by step,
// plus a 2-bit-PC instance with a permanently acking memory to exercise pc wrap.
module tb_instr_sequencer;

    logic clk;
    logic reset;
    logic reset2;
    int   assertCount;
    int   failCount;

    instr_sequencer_if #(.PC_W(8)) bus ();
    instr_sequencer_if #(.PC_W(2)) bus2 ();

    instr_sequencer #(.PC_W(8), .RESET_PC(8'h00), .HALT_OP(4'hF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    instr_sequencer #(.PC_W(2), .RESET_PC(2'd0), .HALT_OP(4'hF)) dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [36:0] mkInstr(input logic [15:0] imm, input logic [3:0] op,
                                            input logic li, input logic rw, input logic [4:0] dst,
                                            input logic [4:0] s1, input logic [4:0] s2);
        return {imm, op, li, rw, dst, s1, s2};
    endfunction

    // Inputs given here are present at the next rising edge; outputs are read 1ns after it.
    task automatic applyStimulus(input logic st, input logic ack, input logic [36:0] data,
                                 input logic done);
        bus.start     = st;
        bus.imem_ack  = ack;
        bus.imem_data = data;
        bus.alu_done  = done;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    logic [36:0] wLi, wAlu, wAluNoWb, wHalt, wLi2, wOther, wJmp, wLiSmall;

    initial begin
        assertCount = 0;
        failCount   = 0;
        wLi      = mkInstr(16'h00AB, 4'h1, 1'b1, 1'b0, 5'd3, 5'd0, 5'd0);
        wAlu     = mkInstr(16'h0000, 4'h2, 1'b0, 1'b1, 5'd4, 5'd1, 5'd2);
        wAluNoWb = mkInstr(16'h0000, 4'h3, 1'b0, 1'b0, 5'd6, 5'd1, 5'd1);
        wHalt    = mkInstr(16'h0000, 4'hF, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        wLi2     = mkInstr(16'h1234, 4'h1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0);
        wOther   = mkInstr(16'h5555, 4'h4, 1'b0, 1'b1, 5'd9, 5'd9, 5'd9);
        wJmp     = mkInstr(16'h0002, 4'hE, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
        wLiSmall = mkInstr(16'h0001, 4'h1, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0);

        bus2.start     = 1'b0;
        bus2.imem_ack  = 1'b1;
        bus2.imem_data = wLiSmall;
        bus2.alu_done  = 1'b0;
        reset2         = 1'b1;

        // Reset values
        reset = 1'b1;
        applyStimulus(0, 0, '0, 0);
        applyStimulus(0, 0, '0, 0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_halted", 32'(bus.halted), 32'd0);
        checkOutput("rst_pc", 32'(bus.pc), 32'd0);
        checkOutput("rst_count", 32'(bus.instr_count), 32'd0);
        checkOutput("rst_req", 32'(bus.imem_req), 32'd0);
        checkOutput("rst_imm", 32'(bus.imm_data), 32'd0);
        checkOutput("rst_opcode", 32'(bus.opcode), 32'd0);
        checkOutput("rst_alu_start", 32'(bus.alu_start), 32'd0);
        checkOutput("rst_rf_we", 32'(bus.rf_we), 32'd0);
        checkOutput("rst_rf_wsel", 32'(bus.rf_wsel), 32'd0);
        reset = 1'b0;

        // LI instruction with zero-wait ack
        applyStimulus(1, 0, '0, 0);
        checkOutput("li_fetch_req", 32'(bus.imem_req), 32'd1);
        checkOutput("li_fetch_addr", 32'(bus.imem_addr), 32'd0);
        checkOutput("li_fetch_busy", 32'(bus.busy), 32'd1);
        applyStimulus(0, 1, wLi, 0);
        checkOutput("li_dec_req", 32'(bus.imem_req), 32'd0);
        checkOutput("li_dec_imm", 32'(bus.imm_data), 32'h00AB);
        checkOutput("li_dec_dst", 32'(bus.dst_addr), 32'd3);
        checkOutput("li_dec_op", 32'(bus.opcode), 32'd1);
        checkOutput("li_dec_we", 32'(bus.rf_we), 32'd0);
        applyStimulus(0, 0, '0, 0);
        checkOutput("li_ret_we", 32'(bus.rf_we), 32'd1);
        checkOutput("li_ret_wsel", 32'(bus.rf_wsel), 32'd1);
        checkOutput("li_ret_pc", 32'(bus.pc), 32'd0);
        applyStimulus(0, 0, '0, 0);
        checkOutput("li_next_pc", 32'(bus.pc), 32'd1);
        checkOutput("li_next_count", 32'(bus.instr_count), 32'd1);
        checkOutput("li_next_we", 32'(bus.rf_we), 32'd0);
        checkOutput("li_next_req", 32'(bus.imem_req), 32'd1);

        // ALU instruction with write-back, alu_done two cycles after alu_start
        applyStimulus(0, 1, wAlu, 0);
        checkOutput("alu_src1", 32'(bus.src1_addr), 32'd1);
        checkOutput("alu_src2", 32'(bus.src2_addr), 32'd2);
        checkOutput("alu_dst", 32'(bus.dst_addr), 32'd4);
        checkOutput("alu_dec_start", 32'(bus.alu_start), 32'd0);
        applyStimulus(0, 0, '0, 0);
        checkOutput("alu_exec1_start", 32'(bus.alu_start), 32'd1);
        applyStimulus(0, 0, '0, 0);
        checkOutput("alu_exec2_start", 32'(bus.alu_start), 32'd0);
        applyStimulus(0, 0, '0, 0);
        checkOutput("alu_exec3_start", 32'(bus.alu_start), 32'd0);
        checkOutput("alu_exec3_we", 32'(bus.rf_we), 32'd0);
        applyStimulus(0, 0, '0, 1);
        checkOutput("alu_ret_we", 32'(bus.rf_we), 32'd1);
        checkOutput("alu_ret_wsel", 32'(bus.rf_wsel), 32'd0);
        applyStimulus(0, 0, '0, 0);
        checkOutput("alu_next_pc", 32'(bus.pc), 32'd2);
        checkOutput("alu_next_count", 32'(bus.instr_count), 32'd2);

        // HALT at pc=2: frozen, start ignored, left only through reset
        applyStimulus(0, 1, wHalt, 0);
        checkOutput("halt_dec_op", 32'(bus.opcode), 32'hF);
        applyStimulus(0, 0, '0, 0);
        checkOutput("halt_halted", 32'(bus.halted), 32'd1);
        checkOutput("halt_busy", 32'(bus.busy), 32'd0);
        checkOutput("halt_pc", 32'(bus.pc), 32'd2);
        checkOutput("halt_count", 32'(bus.instr_count), 32'd2);
        applyStimulus(1, 1, wLi, 1);
        applyStimulus(1, 1, wLi, 1);
        checkOutput("halt_hold_halted", 32'(bus.halted), 32'd1);
        checkOutput("halt_hold_pc", 32'(bus.pc), 32'd2);
        checkOutput("halt_hold_count", 32'(bus.instr_count), 32'd2);
        checkOutput("halt_hold_req", 32'(bus.imem_req), 32'd0);
        reset = 1'b1;
        applyStimulus(0, 0, '0, 0);
        checkOutput("halt_rst_halted", 32'(bus.halted), 32'd0);
        checkOutput("halt_rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("halt_rst_pc", 32'(bus.pc), 32'd0);
        checkOutput("halt_rst_count", 32'(bus.instr_count), 32'd0);
        checkOutput("halt_rst_op", 32'(bus.opcode), 32'd0);
        reset = 1'b0;

        // ALU without write-back, alu_done already high in the first EXEC cycle
        applyStimulus(1, 0, '0, 0);
        applyStimulus(0, 1, wAluNoWb, 0);
        applyStimulus(0, 0, '0, 1);
        checkOutput("nowb_exec_start", 32'(bus.alu_start), 32'd1);
        applyStimulus(0, 0, '0, 1);
        checkOutput("nowb_ret_busy", 32'(bus.busy), 32'd1);
        checkOutput("nowb_ret_we", 32'(bus.rf_we), 32'd0);
        checkOutput("nowb_ret_wsel", 32'(bus.rf_wsel), 32'd0);
        applyStimulus(0, 0, '0, 0);
        checkOutput("nowb_next_pc", 32'(bus.pc), 32'd1);
        checkOutput("nowb_next_count", 32'(bus.instr_count), 32'd1);
        checkOutput("nowb_next_start", 32'(bus.alu_start), 32'd0);

        // Ack delayed 5 cycles with stray alu_done; stray ack in DECODE must not reload IR
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("wait%0d_req", i), 32'(bus.imem_req), 32'd1);
            checkOutput($sformatf("wait%0d_addr", i), 32'(bus.imem_addr), 32'd1);
            applyStimulus(0, 0, '0, 1);
        end
        checkOutput("wait5_req", 32'(bus.imem_req), 32'd1);
        checkOutput("wait5_addr", 32'(bus.imem_addr), 32'd1);
        applyStimulus(0, 1, wLi2, 0);
        checkOutput("wait_dec_req", 32'(bus.imem_req), 32'd0);
        checkOutput("wait_dec_imm", 32'(bus.imm_data), 32'h1234);
        applyStimulus(0, 1, wOther, 0);
        checkOutput("stray_ack_imm", 32'(bus.imm_data), 32'h1234);
        checkOutput("stray_ack_dst", 32'(bus.dst_addr), 32'd7);
        checkOutput("wait_ret_we", 32'(bus.rf_we), 32'd1);
        applyStimulus(0, 0, '0, 0);
        checkOutput("wait_next_pc", 32'(bus.pc), 32'd2);
        checkOutput("wait_next_count", 32'(bus.instr_count), 32'd2);

        // Opcode 4'hE with LI=1 at pc=2
        applyStimulus(0, 1, wJmp, 0);
        applyStimulus(0, 0, '0, 0);
`ifdef SEQ_JUMP_EN
        checkOutput("jmp_ret_we", 32'(bus.rf_we), 32'd0);
        applyStimulus(0, 0, '0, 0);
        checkOutput("jmp_pc", 32'(bus.pc), 32'd2);
`else
        checkOutput("opE_ret_we", 32'(bus.rf_we), 32'd1);
        checkOutput("opE_ret_wsel", 32'(bus.rf_wsel), 32'd1);
        applyStimulus(0, 0, '0, 0);
        checkOutput("opE_pc", 32'(bus.pc), 32'd3);
`endif
        checkOutput("opE_count", 32'(bus.instr_count), 32'd3);

        // Reset asserted during EXEC
        applyStimulus(0, 1, wAlu, 0);
        applyStimulus(0, 0, '0, 0);
        checkOutput("rstx_exec_start", 32'(bus.alu_start), 32'd1);
        reset = 1'b1;
        applyStimulus(0, 0, '0, 1);
        checkOutput("rstx_req", 32'(bus.imem_req), 32'd0);
        checkOutput("rstx_alu_start", 32'(bus.alu_start), 32'd0);
        checkOutput("rstx_rf_we", 32'(bus.rf_we), 32'd0);
        checkOutput("rstx_busy", 32'(bus.busy), 32'd0);
        checkOutput("rstx_pc", 32'(bus.pc), 32'd0);
        reset = 1'b0;

        // PC_W=2 instance: four LI words with ack always high, pc wraps 3 -> 0
        reset2     = 1'b0;
        bus2.start = 1'b1;
        @(posedge clk);
        #1;
        bus2.start = 1'b0;
        checkOutput("w2_fetch_req", 32'(bus2.imem_req), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            repeat (3) begin
                @(posedge clk);
                #1;
            end
            checkOutput($sformatf("w2_pc%0d", k), 32'(bus2.pc), 32'(k % 4));
        end
        checkOutput("w2_count", 32'(bus2.instr_count), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
